// File: rtl/rr_arb_pkg.sv
// Shared types and default sizing for the round-robin burst arbiter.
package rr_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  localparam int N_REQ_DEF  = 4;
  localparam int HOLD_W_DEF = 4;

endpackage : rr_arb_pkg

// File: rtl/rr_pick.sv
// Rotating-priority picker: finds the first asserted request at or after
// the start index, wrapping from N_REQ-1 back to 0.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] start,
  output logic [N_REQ-1:0]         onehot,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     found
);

  localparam int IDX_W = $clog2(N_REQ);

  int               pos;
  logic [IDX_W-1:0] sel;

  // Walk the requesters in priority order and keep the first hit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    sel    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = (int'(start) + k) % N_REQ;
      sel = IDX_W'(pos);
      if (!found && req[sel]) begin
        found       = 1'b1;
        idx         = sel;
        onehot[sel] = 1'b1;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with a per-ownership burst limit. An owner keeps the
// grant while it requests and its hold budget lasts; on expiry the grant
// rotates to the next requester (flagged by preempt), or is renewed when the
// owner is the only one asking.
module rr_burst_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int HOLD_W = HOLD_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [HOLD_W-1:0]        max_hold,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     preempt
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e        state;
  logic [IDX_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;

  logic              owner_req;
  logic              expire;
  logic              take;
  logic              drop;

  // Next index after i, wrapping at the last requester.
  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N_REQ - 1)) return '0;
    return i + IDX_W'(1);
  endfunction

  // Hold counter saturates so a long unlimited burst still compares as
  // "at or beyond" any limit that is programmed later.
  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] c);
    if (&c) return c;
    return c + HOLD_W'(1);
  endfunction

  // While owned, ptr is always owner+1, so one search from ptr serves both
  // the idle grant and the handover/expiry search.
  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req),
    .start  (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Decide whether this edge issues a new grant or releases the bus.
  always_comb begin
    owner_req = req[grant_id];
    expire    = (max_hold != '0) && (hold_cnt >= (max_hold - HOLD_W'(1)));
    take      = 1'b0;
    drop      = 1'b0;
    if (state == ST_IDLE) begin
      take = pick_found;
    end else if (!owner_req || expire) begin
      take = pick_found;
      drop = !pick_found;
    end
  end

  // Ownership FSM with registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      preempt <= 1'b0;
      if (take) begin
        state    <= ST_OWNED;
        grant    <= pick_onehot;
        grant_id <= pick_idx;
        busy     <= 1'b1;
        ptr      <= inc_wrap(pick_idx);
        hold_cnt <= '0;
        preempt  <= (state == ST_OWNED) && owner_req && (pick_idx != grant_id);
      end else if (drop) begin
        state    <= ST_IDLE;
        grant    <= '0;
        grant_id <= '0;
        busy     <= 1'b0;
      end else if (state == ST_OWNED) begin
        hold_cnt <= sat_inc(hold_cnt);
      end
    end
  end

endmodule : rr_burst_arbiter
